// File: rtl/grid_io_cfg_bank.sv
// Right-edge I/O bank tile: NUM_IO pads behind a shadowed config chain segment.
// Shift into the shadow register, commit atomically to the active register, rotate for readback.
module grid_io_pad_lane (
  input  logic cfg_bit,
  input  logic isol_n,
  input  logic pad_val,
  input  logic fab_val,
  output logic dir,
  output logic pad_drive,
  output logic fab_pick
);
  // cfg_bit=1 selects input mode; isolation forces the safe input state with nothing driven
  assign dir       = ~isol_n | cfg_bit;
  assign pad_drive = isol_n & ~cfg_bit & fab_val;
  assign fab_pick  = isol_n & cfg_bit & pad_val;
endmodule

module grid_io_cfg_bank #(
  parameter int NUM_IO = 4,
  parameter int CW     = $clog2(NUM_IO+1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              ccff_head,
  input  logic              ccff_shift_en,
  input  logic              ccff_readback,
  input  logic              ccff_commit,
  input  logic              isol_n,
  input  logic [NUM_IO-1:0] gfpga_pad_io_soc_in,
  input  logic [NUM_IO-1:0] core_outpad,
  output logic              ccff_tail,
  output logic [NUM_IO-1:0] gfpga_pad_io_soc_out,
  output logic [NUM_IO-1:0] gfpga_pad_io_soc_dir,
  output logic [NUM_IO-1:0] core_inpad,
  output logic [CW-1:0]     cfg_count,
  output logic              cfg_ready,
  output logic              cfg_overrun,
  output logic              commit_rej
);
  localparam int RW = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
  localparam logic [CW-1:0] FULL    = CW'(NUM_IO);
  localparam logic [RW-1:0] ROT_MAX = RW'(NUM_IO-1);

  typedef enum logic [1:0] {EMPTY, LOADING, READY, OVERRUN} state_t;

  state_t            state;
  logic [NUM_IO-1:0] shadow, active;
  logic [RW-1:0]     rot_pos;
  logic              load_shift, rb_shift, commit_ok, shift_in;

  assign load_shift = ccff_shift_en & ~ccff_readback;
  assign rb_shift   = ccff_shift_en & ccff_readback;
  // Only a fully loaded, un-rotated shadow may be committed
  assign commit_ok  = ccff_commit && (state == READY) && (rot_pos == '0);
  assign shift_in   = ccff_readback ? shadow[NUM_IO-1] : ccff_head;
  assign ccff_tail  = shadow[NUM_IO-1];

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state       <= EMPTY;
      shadow      <= '0;
      active      <= '1;
      rot_pos     <= '0;
      cfg_count   <= '0;
      cfg_ready   <= 1'b0;
      cfg_overrun <= 1'b0;
      commit_rej  <= 1'b0;
    end else begin
      commit_rej <= ccff_commit & ~commit_ok;
      if (ccff_shift_en) shadow <= (shadow << 1) | NUM_IO'(shift_in);
      if (commit_ok) active <= shadow;
      if (rb_shift) rot_pos <= (rot_pos == ROT_MAX) ? '0 : rot_pos + RW'(1);

      if (commit_ok) begin
        // A load shift in the commit cycle is the first bit of the next load
        cfg_overrun <= 1'b0;
        cfg_count   <= load_shift ? CW'(1) : '0;
        cfg_ready   <= load_shift && (FULL == CW'(1));
        state       <= !load_shift ? EMPTY : (FULL == CW'(1)) ? READY : LOADING;
      end else if (load_shift) begin
        case (state)
          EMPTY, LOADING: begin
            cfg_count <= cfg_count + CW'(1);
            cfg_ready <= (cfg_count + CW'(1)) == FULL;
            state     <= ((cfg_count + CW'(1)) == FULL) ? READY : LOADING;
          end
          READY: begin
            cfg_overrun <= 1'b1;
            cfg_ready   <= 1'b0;
            state       <= OVERRUN;
          end
          default: begin
            // Overrun recovery: this shift starts a fresh load
            cfg_overrun <= 1'b0;
            cfg_count   <= CW'(1);
            cfg_ready   <= FULL == CW'(1);
            state       <= (FULL == CW'(1)) ? READY : LOADING;
          end
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_IO; i++) begin : g_lane
    grid_io_pad_lane u_lane (
      .cfg_bit   (active[i]),
      .isol_n    (isol_n),
      .pad_val   (gfpga_pad_io_soc_in[i]),
      .fab_val   (core_outpad[i]),
      .dir       (gfpga_pad_io_soc_dir[i]),
      .pad_drive (gfpga_pad_io_soc_out[i]),
      .fab_pick  (core_inpad[i])
    );
  end
endmodule

// File: tb/tb_grid_io_cfg_bank.sv
// Directed vector table plus a short hand sequence for grid_io_cfg_bank (NUM_IO=4).
module tb_grid_io_cfg_bank;
  logic       prog_clk = 1'b0, prog_reset, ccff_head, ccff_shift_en, ccff_readback, ccff_commit, isol_n;
  logic [3:0] soc_in, outpad;
  logic       ccff_tail, cfg_ready, cfg_overrun, commit_rej;
  logic [3:0] soc_out, soc_dir, inpad;
  logic [2:0] cfg_count;
  int checks = 0, failures = 0;

  always #5 prog_clk = ~prog_clk;

  grid_io_cfg_bank #(.NUM_IO(4)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .ccff_head(ccff_head),
    .ccff_shift_en(ccff_shift_en), .ccff_readback(ccff_readback), .ccff_commit(ccff_commit),
    .isol_n(isol_n), .gfpga_pad_io_soc_in(soc_in), .core_outpad(outpad),
    .ccff_tail(ccff_tail), .gfpga_pad_io_soc_out(soc_out), .gfpga_pad_io_soc_dir(soc_dir),
    .core_inpad(inpad), .cfg_count(cfg_count), .cfg_ready(cfg_ready),
    .cfg_overrun(cfg_overrun), .commit_rej(commit_rej)
  );

  typedef struct {
    logic       rst, head, sh, rb, cm, isol;
    logic [3:0] sin, opad;
    logic       tail;
    logic [3:0] dir, sout, inp;
    logic [2:0] cnt;
    logic       rdy, ovr, rej;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%b want=%b", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, head, sh, rb, cm, isol, input logic [3:0] sin, opad,
                     input logic tail, input logic [3:0] dir, sout, inp, input logic [2:0] cnt,
                     input logic rdy, ovr, rej);
    vec_t v;
    v.rst = rst; v.head = head; v.sh = sh; v.rb = rb; v.cm = cm; v.isol = isol;
    v.sin = sin; v.opad = opad; v.tail = tail; v.dir = dir; v.sout = sout; v.inp = inp;
    v.cnt = cnt; v.rdy = rdy; v.ovr = ovr; v.rej = rej;
    vq.push_back(v);
  endtask

  task automatic drive(input logic rst, head, sh, rb, cm, isol, input logic [3:0] sin, opad);
    prog_reset = rst; ccff_head = head; ccff_shift_en = sh; ccff_readback = rb;
    ccff_commit = cm; isol_n = isol; soc_in = sin; outpad = opad;
  endtask

  initial begin
    //   rst h sh rb cm is  sin      opad      tail dir      sout     inp      cnt  rdy ovr rej
    // reset
    add(1,0,0,0,0,1, 4'b0101,4'b0110, 0,4'b1111,4'b0000,4'b0101,3'd0, 0,0,0);
    add(1,0,0,0,0,1, 4'b0101,4'b0110, 0,4'b1111,4'b0000,4'b0101,3'd0, 0,0,0);
    // load 1,1,0,1 -> S=1101, first bit reaches tail after the 4th edge
    add(0,1,1,0,0,1, 4'b0101,4'b0110, 0,4'b1111,4'b0000,4'b0101,3'd1, 0,0,0);
    add(0,1,1,0,0,1, 4'b0101,4'b0110, 0,4'b1111,4'b0000,4'b0101,3'd2, 0,0,0);
    add(0,0,1,0,0,1, 4'b0101,4'b0110, 0,4'b1111,4'b0000,4'b0101,3'd3, 0,0,0);
    add(0,1,1,0,0,1, 4'b0101,4'b0110, 1,4'b1111,4'b0000,4'b0101,3'd4, 1,0,0);
    // commit -> A=1101: pad1 is an output, others pass pad to fabric
    add(0,0,0,0,1,1, 4'b0101,4'b0110, 1,4'b1101,4'b0010,4'b0101,3'd0, 0,0,0);
    add(0,0,0,0,0,1, 4'b0100,4'b0000, 1,4'b1101,4'b0000,4'b0100,3'd0, 0,0,0);
    // five load shifts 1,0,0,1,0 -> overrun
    add(0,1,1,0,0,1, 4'b0101,4'b0110, 1,4'b1101,4'b0010,4'b0101,3'd1, 0,0,0);
    add(0,0,1,0,0,1, 4'b0101,4'b0110, 0,4'b1101,4'b0010,4'b0101,3'd2, 0,0,0);
    add(0,0,1,0,0,1, 4'b0101,4'b0110, 1,4'b1101,4'b0010,4'b0101,3'd3, 0,0,0);
    add(0,1,1,0,0,1, 4'b0101,4'b0110, 1,4'b1101,4'b0010,4'b0101,3'd4, 1,0,0);
    add(0,0,1,0,0,1, 4'b0101,4'b0110, 0,4'b1101,4'b0010,4'b0101,3'd4, 0,1,0);
    // commit in overrun is rejected, one-cycle pulse, A unchanged
    add(0,0,0,0,1,1, 4'b0101,4'b0110, 0,4'b1101,4'b0010,4'b0101,3'd4, 0,1,1);
    add(0,0,0,0,0,1, 4'b0101,4'b0110, 0,4'b1101,4'b0010,4'b0101,3'd4, 0,1,0);
    // reload 0,1,1,0 -> overrun clears, S=0110, ready
    add(0,0,1,0,0,1, 4'b0101,4'b0110, 0,4'b1101,4'b0010,4'b0101,3'd1, 0,0,0);
    add(0,1,1,0,0,1, 4'b0101,4'b0110, 1,4'b1101,4'b0010,4'b0101,3'd2, 0,0,0);
    add(0,1,1,0,0,1, 4'b0101,4'b0110, 0,4'b1101,4'b0010,4'b0101,3'd3, 0,0,0);
    add(0,0,1,0,0,1, 4'b0101,4'b0110, 0,4'b1101,4'b0010,4'b0101,3'd4, 1,0,0);
    // two readback shifts, commit rejected, two more restore S
    add(0,1,1,1,0,1, 4'b0101,4'b0110, 1,4'b1101,4'b0010,4'b0101,3'd4, 1,0,0);
    add(0,0,1,1,0,1, 4'b0101,4'b0110, 1,4'b1101,4'b0010,4'b0101,3'd4, 1,0,0);
    add(0,0,0,0,1,1, 4'b0101,4'b0110, 1,4'b1101,4'b0010,4'b0101,3'd4, 1,0,1);
    add(0,0,1,1,0,1, 4'b0101,4'b0110, 0,4'b1101,4'b0010,4'b0101,3'd4, 1,0,0);
    add(0,1,1,1,0,1, 4'b0101,4'b0110, 0,4'b1101,4'b0010,4'b0101,3'd4, 1,0,0);
    // commit accepted -> A=0110
    add(0,0,0,0,1,1, 4'b0101,4'b1111, 0,4'b0110,4'b1001,4'b0100,3'd0, 0,0,0);
    // load 1,0,0,1 -> S=1001
    add(0,1,1,0,0,1, 4'b0101,4'b1111, 1,4'b0110,4'b1001,4'b0100,3'd1, 0,0,0);
    add(0,0,1,0,0,1, 4'b0101,4'b1111, 1,4'b0110,4'b1001,4'b0100,3'd2, 0,0,0);
    add(0,0,1,0,0,1, 4'b0101,4'b1111, 0,4'b0110,4'b1001,4'b0100,3'd3, 0,0,0);
    add(0,1,1,0,0,1, 4'b0101,4'b1111, 1,4'b0110,4'b1001,4'b0100,3'd4, 1,0,0);
    // shift and commit together: A=pre-shift 1001, count=1
    add(0,0,1,0,1,1, 4'b0101,4'b1111, 0,4'b1001,4'b0110,4'b0001,3'd1, 0,0,0);
    // three zeros -> S=0000, commit -> A=0000
    add(0,0,1,0,0,1, 4'b0101,4'b1111, 0,4'b1001,4'b0110,4'b0001,3'd2, 0,0,0);
    add(0,0,1,0,0,1, 4'b0101,4'b1111, 1,4'b1001,4'b0110,4'b0001,3'd3, 0,0,0);
    add(0,0,1,0,0,1, 4'b0101,4'b1111, 0,4'b1001,4'b0110,4'b0001,3'd4, 1,0,0);
    add(0,0,0,0,1,1, 4'b0101,4'b1111, 0,4'b0000,4'b1111,4'b0000,3'd0, 0,0,0);
    // isolation forces safe pads but the chain still shifts
    add(0,1,1,0,0,0, 4'b0101,4'b1111, 0,4'b1111,4'b0000,4'b0000,3'd1, 0,0,0);
    add(0,0,0,0,0,1, 4'b0101,4'b1111, 0,4'b0000,4'b1111,4'b0000,3'd1, 0,0,0);
    // mid-load reset (with shift and commit asserted) discards S=0011
    add(0,1,1,0,0,1, 4'b0101,4'b1111, 0,4'b0000,4'b1111,4'b0000,3'd2, 0,0,0);
    add(1,1,1,0,1,1, 4'b0101,4'b1111, 0,4'b1111,4'b0000,4'b0101,3'd0, 0,0,0);
    add(0,0,1,0,0,1, 4'b0101,4'b1111, 0,4'b1111,4'b0000,4'b0101,3'd1, 0,0,0);
    add(0,0,1,0,0,1, 4'b0101,4'b1111, 0,4'b1111,4'b0000,4'b0101,3'd2, 0,0,0);

    drive(1,0,0,0,0,1, 4'b0000, 4'b0000);
    @(negedge prog_clk);
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].head, vq[i].sh, vq[i].rb, vq[i].cm, vq[i].isol, vq[i].sin, vq[i].opad);
      @(posedge prog_clk); #1;
      chk("tail",    i, {3'b0, ccff_tail},   {3'b0, vq[i].tail});
      chk("dir",     i, soc_dir,             vq[i].dir);
      chk("soc_out", i, soc_out,             vq[i].sout);
      chk("inpad",   i, inpad,               vq[i].inp);
      chk("count",   i, {1'b0, cfg_count},   {1'b0, vq[i].cnt});
      chk("ready",   i, {3'b0, cfg_ready},   {3'b0, vq[i].rdy});
      chk("overrun", i, {3'b0, cfg_overrun}, {3'b0, vq[i].ovr});
      chk("rej",     i, {3'b0, commit_rej},  {3'b0, vq[i].rej});
    end

    // Hand sequence: shift zeros until ready (bounded), commit makes every pad an output
    begin
      int cyc;
      drive(1,0,0,0,0,1, 4'b1111, 4'b1010);
      @(posedge prog_clk); #1;
      drive(0,0,1,0,0,1, 4'b1111, 4'b1010);
      cyc = 0;
      while (!cfg_ready && cyc < 20) begin
        @(posedge prog_clk); #1;
        cyc++;
      end
      chk("ready_wait_cycles", 100, 4'(cyc), 4'd4);
      drive(0,0,0,0,1,1, 4'b1111, 4'b1010);
      @(posedge prog_clk); #1;
      chk("hand_dir",     100, soc_dir, 4'b0000);
      chk("hand_soc_out", 100, soc_out, 4'b1010);
      chk("hand_inpad",   100, inpad,   4'b0000);
      drive(0,0,0,0,0,0, 4'b1111, 4'b1010);
      #1;
      chk("hand_isol_dir", 100, soc_dir, 4'b1111);
      chk("hand_isol_out", 100, soc_out, 4'b0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
